// File: rtl/uart_mem_dump.sv
// Streams a window of RAM words out of an 8N1 UART transmitter, LSB byte first.
// Optional trailing two's-complement checksum byte under UART_MEM_DUMP_CHECKSUM_EN.
module uart_mem_dump #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LEN_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_words_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_STOP = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
`ifdef UART_MEM_DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LEN_W-1:0]  r_left, w_left_nxt;
  logic [31:0]       r_word, w_word_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]        r_bit, w_bit_nxt;
  logic [1:0]        r_byte, w_byte_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_req, r_busy, r_done;
`ifdef UART_MEM_DUMP_CHECKSUM_EN
  logic [7:0]        r_sum, w_sum_nxt;
`endif

  // Line level for frame position idx: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic tx_level(input logic [3:0] idx, input logic [7:0] data);
    if (idx == 4'd0)          return 1'b0;
    else if (idx >= BIT_STOP) return 1'b1;
    else                      return data[3'(idx - 4'd1)];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_left_nxt  = r_left;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_tx_nxt    = r_tx;
`ifdef UART_MEM_DUMP_CHECKSUM_EN
    w_sum_nxt   = r_sum;
`endif
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_addr_nxt = base_addr_i & ~ADDR_W'(3);
          w_left_nxt = len_words_i;
`ifdef UART_MEM_DUMP_CHECKSUM_EN
          w_sum_nxt  = 8'h00;
`endif
          if (len_words_i != LEN_W'(0)) begin
            w_state_nxt = S_REQ;
          end else begin
`ifdef UART_MEM_DUMP_CHECKSUM_EN
            w_word_nxt  = 32'h0;
            w_cnt_nxt   = '0;
            w_bit_nxt   = 4'd0;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_FIN;
`endif
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_word_nxt  = mem_rdata_i;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 4'd0;
          w_byte_nxt  = 2'd0;
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_SEND;
        end
      end
`ifdef UART_MEM_DUMP_CHECKSUM_EN
      S_SEND, S_CSUM: begin
`else
      S_SEND: begin
`endif
        if (r_cnt != CNT_LAST) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = '0;
          if (r_bit != BIT_STOP) begin
            w_bit_nxt = r_bit + 4'd1;
            w_tx_nxt  = tx_level(r_bit + 4'd1, r_word[7:0]);
          end else begin
            // Stop bit done: default to the next byte's start bit.
            w_bit_nxt  = 4'd0;
            w_tx_nxt   = 1'b0;
            w_word_nxt = {8'h00, r_word[31:8]};
`ifdef UART_MEM_DUMP_CHECKSUM_EN
            w_sum_nxt  = r_sum + r_word[7:0];
`endif
            if (r_state == S_SEND) begin
              if (r_byte != 2'd3) begin
                w_byte_nxt = r_byte + 2'd1;
              end else begin
                w_byte_nxt = 2'd0;
                w_addr_nxt = r_addr + ADDR_W'(4);
                w_left_nxt = r_left - LEN_W'(1);
                if (r_left != LEN_W'(1)) begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = S_REQ;
                end else begin
`ifdef UART_MEM_DUMP_CHECKSUM_EN
                  w_word_nxt  = {24'h0, 8'(8'h00 - w_sum_nxt)};
                  w_state_nxt = S_CSUM;
`else
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = S_FIN;
`endif
                end
              end
            end else begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = S_FIN;
            end
          end
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs follow the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_left <= '0;
      r_word <= '0;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_byte <= '0;
      r_tx   <= 1'b1;
      r_req  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef UART_MEM_DUMP_CHECKSUM_EN
      r_sum  <= '0;
`endif
    end else begin
      r_addr <= w_addr_nxt;
      r_left <= w_left_nxt;
      r_word <= w_word_nxt;
      r_cnt  <= w_cnt_nxt;
      r_bit  <= w_bit_nxt;
      r_byte <= w_byte_nxt;
      r_tx   <= w_tx_nxt;
      r_req  <= (w_state_nxt == S_REQ);
      r_busy <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
      r_done <= (w_state_nxt == S_FIN);
`ifdef UART_MEM_DUMP_CHECKSUM_EN
      r_sum  <= w_sum_nxt;
`endif
    end
  end

  assign mem_req_o  = r_req;
  assign mem_addr_o = r_addr;
  assign uart_tx_o  = r_tx;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Randomized bench for uart_mem_dump: RAM responder, UART receiver and byte-stream model.
module tb_uart_mem_dump;
  localparam int unsigned CPB = 4;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] len_words_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;

  uart_mem_dump #(.CLKS_PER_BIT(CPB), .ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_words_i(len_words_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .uart_tx_o(uart_tx_o), .busy_o(busy_o), .done_o(done_o)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] ram [256];
  logic [31:0] exp_addr [$];
  logic [7:0]  rx_q [$];
  int          stall_lo = 0, stall_hi = 3, lat_lo = 1, lat_hi = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM side: random grant stall and read latency, junk rvalid when not fetching.
  initial begin
    logic [31:0] a;
    int st, lt;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i  = $urandom;
      if (mem_req_o && rst_n) begin
        a = mem_addr_o;
        mem_rvalid_i = 1'b0;
        if (exp_addr.size() == 0) check("req_pending", 32'(exp_addr.size()), 32'd1);
        else                      check("req_addr", a, exp_addr.pop_front());
        st = $urandom_range(stall_hi, stall_lo);
        lt = $urandom_range(lat_hi, lat_lo);
        for (int i = 0; i < st; i++) begin
          mem_rvalid_i = 1'($urandom_range(0, 1));
          mem_rdata_i  = $urandom;
          @(negedge clk);
          check("stall_req", 32'(mem_req_o), 32'd1);
          check("stall_addr", mem_addr_o, a);
          check("stall_tx", 32'(uart_tx_o), 32'd1);
        end
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check("req_drop", 32'(mem_req_o), 32'd0);
        repeat (lt - 1) @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = ram[a[9:2]];
      end
    end
  end

  // UART receiver: every bit must hold for exactly CPB samples; aborts on reset.
  initial begin
    logic [9:0] bits;
    bit glitch, ab;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx_o == 1'b0) begin
        glitch = 1'b0; ab = 1'b0; bits = '0;
        for (int k = 0; k < 10 && !ab; k++) begin
          for (int j = 0; j < int'(CPB) && !ab; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (!rst_n) ab = 1'b1;
            else if (j == 0) bits[k] = uart_tx_o;
            else if (uart_tx_o !== bits[k]) glitch = 1'b1;
          end
        end
        if (!ab) begin
          check("frame_stop", 32'(bits[9]), 32'd1);
          check("frame_width", 32'(glitch), 32'd0);
          rx_q.push_back(bits[8:1]);
        end
      end
    end
  end

  task automatic run_dump(input logic [31:0] base, input logic [15:0] len, input bit poke);
    logic [7:0]  exp_b [$];
    logic [31:0] a, w;
    logic [7:0]  sum;
    int          budget;
    bit          got;
    rx_q.delete();
    a = base & ~32'h3;
    sum = 8'h00;
    for (int i = 0; i < int'(len); i++) begin
      w = ram[a[9:2]];
      exp_addr.push_back(a);
      for (int k = 0; k < 4; k++) begin
        exp_b.push_back(w[8*k +: 8]);
        sum = sum + w[8*k +: 8];
      end
      a = a + 32'd4;
    end
`ifdef UART_MEM_DUMP_CHECKSUM_EN
    exp_b.push_back(8'(8'h00 - sum));
`endif
    base_addr_i = base; len_words_i = len; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
`ifndef UART_MEM_DUMP_CHECKSUM_EN
    if (len == 16'd0) begin
      check("len0_done", 32'(done_o), 32'd1);
      check("len0_req", 32'(mem_req_o), 32'd0);
    end else
`endif
      check("busy_rise", 32'(busy_o), 32'd1);
    budget = (int'(len) + 1) * (40 * int'(CPB) + 40) + 20;
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done_o) begin got = 1'b1; break; end
      start_i = poke && (c == 50);
      if (poke) begin base_addr_i = $urandom; len_words_i = 16'($urandom); end
      @(negedge clk);
    end
    start_i = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("busy_at_done", 32'(busy_o), 32'd0);
    check("addr_all_fetched", 32'(exp_addr.size()), 32'd0);
    exp_addr.delete();
    @(negedge clk);
    check("done_pulse", 32'(done_o), 32'd0);
    check("idle_tx", 32'(uart_tx_o), 32'd1);
    repeat (2) @(negedge clk);
    check("byte_count", 32'(rx_q.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
      check("byte", 32'(rx_q[i]), 32'(exp_b[i]));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = 32'h0; len_words_i = 16'h0;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx_o), 32'd1);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    ram[0] = 32'h1122_3344;
    run_dump(32'h0, 16'd1, 1'b0);

    ram[8'h40] = 32'hA5A5_A5A5; ram[8'h41] = 32'h0; ram[8'h42] = 32'hFFFF_FFFF;
    run_dump(32'h102, 16'd3, 1'b0);

    stall_lo = 7; stall_hi = 7; lat_lo = 3; lat_hi = 3;
    run_dump(32'h40, 16'd2, 1'b0);
    stall_lo = 0; stall_hi = 3; lat_lo = 1; lat_hi = 4;

    run_dump(32'h20, 16'd0, 1'b0);
    run_dump(32'h24, 16'd2, 1'b1);

    // Reset during the data bits of the second byte of an all-zero word.
    ram[8'h30] = 32'h0;
    rx_q.delete();
    exp_addr.push_back(32'hC0);
    base_addr_i = 32'hC0; len_words_i = 16'd2; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (rx_q.size() == 1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_byte1_seen", 32'(seen), 32'd1);
    repeat (CPB + 2) @(negedge clk);
    check("pre_rst_tx", 32'(uart_tx_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(uart_tx_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_req", 32'(mem_req_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_addr.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done_o), 32'd0);
    end
    check("post_rst_rx", 32'(rx_q.size()), 32'd1);
    run_dump(32'h84, 16'd2, 1'b0);

    run_dump(32'hFFFF_FFFA, 16'd3, 1'b0);
    for (int r = 0; r < 8; r++)
      run_dump($urandom, 16'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
